lsu: RTL and testbench

Load/store unit directly downstream of the ALU: it takes the ALU result as the effective address and performs one byte, halfword or word access to data memory over a req/ack handshake. It generates byte enables and replicated write data for stores, and extracts and sign- or zero-extends load data. It flags misaligned accesses and memory timeouts, and drives `busy` to stall the pipeline while an access is outstanding.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_if.sv | 15 +
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu.sv | 120 ++++++++++++
 tb/tb_lsu.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and types for the load/store unit.
package lsu_pkg;

  localparam int DEF_TIMEOUT = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // Access attributes held for the whole transaction (load extract needs them at ack).
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sign_ext;
    logic [1:0] off;
  } acc_t;

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store enables/replication/misalign check,
// and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        bad,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  lb;
  logic [15:0] lh;

  // Store side: lane enables, replicated data, illegal size/alignment.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = st_wdata;
    bad       = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        be        = 4'b0001 << st_off;
        wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = st_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{st_wdata[15:0]}};
        bad       = st_off[0];
      end
      SZ_WORD: begin
        be  = 4'b1111;
        bad = |st_off;
      end
      default: bad = 1'b1;
    endcase
  end

  // Load side: pick the addressed lane and extend to 32 bits.
  always_comb begin
    lb = ld_word[{ld_off, 3'b000} +: 8];
    lh = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sign & lb[7]}}, lb};
      SZ_HALF: ld_data = {{16{ld_sign & lh[15]}}, lh};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory access per start, req/ack handshake with
// timeout, misalignment detection and a busy stall to the pipeline.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  lsu_if.master       mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  acc_t           acc;
  logic [CW-1:0]  cnt;
  logic [3:0]     be;
  logic [31:0]    wdata_rep;
  logic           bad;
  logic [31:0]    ld_data;

  // Store side sees the live request; load side sees the latched access.
  lsu_align u_align (
    .st_size   (size),
    .st_off    (addr[1:0]),
    .st_wdata  (wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .bad       (bad),
    .ld_size   (acc.size),
    .ld_off    (acc.off),
    .ld_sign   (acc.sign_ext),
    .ld_word   (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  // Access FSM with registered bus outputs and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata         <= '0;
      addr_err      <= 1'b0;
      bus_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc           <= '{we: we, size: size, sign_ext: sign_ext, off: addr[1:0]};
            mem.mem_addr  <= addr[31:2];
            mem.mem_be    <= be;
            mem.mem_wdata <= wdata_rep;
            cnt           <= '0;
            busy          <= 1'b1;
            if (bad) begin
              // Illegal access completes immediately without touching memory.
              state    <= RESP;
              done     <= 1'b1;
              addr_err <= 1'b1;
            end else begin
              state       <= REQ;
              mem.mem_req <= 1'b1;
              mem.mem_we  <= we;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state       <= RESP;
            done        <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            if (!acc.we) rdata <= ld_data;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Last allowed REQ cycle passed with no ack: abort.
            state       <= RESP;
            done        <= 1'b1;
            bus_err     <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected completions are queued when an access is
// issued and compared when done pulses; a small memory responder acks on cue.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, addr_err, bus_err;
  logic [31:0] rdata;

  lsu_if mif();

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .addr_err(addr_err), .bus_err(bus_err),
    .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        aerr, berr;
    int          lat, nreq;
    logic [29:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mwe;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [1:0] sz, input logic [1:0] off,
                                      input logic s, input logic [31:0] w);
    logic [31:0] sh;
    if (sz == SZ_BYTE) begin
      sh = w >> (8 * off);
      return (s && sh[7]) ? {24'hFFFFFF, sh[7:0]} : {24'h0, sh[7:0]};
    end else if (sz == SZ_HALF) begin
      sh = w >> (16 * (off / 2));
      return (s && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0, sh[15:0]};
    end
    return w;
  endfunction

  // Issue one access; dly = REQ cycle in which memory acks (0 = never).
  task automatic access(input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int dly);
    exp_t e, r;
    logic bad, ok;
    int   cyc, nreq;
    logic got;
    bad = (sz == 2'b11) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
    ok  = (dly >= 1 && dly <= TO);
    e.aerr  = bad;
    e.berr  = !bad && !ok;
    e.lat   = bad ? 1 : (ok ? dly + 1 : TO + 1);
    e.nreq  = bad ? 0 : (ok ? dly : TO);
    e.maddr = a[31:2];
    e.mwe   = w;
    if (sz == SZ_BYTE)      begin e.be = 4'b0001 << a[1:0]; e.wd = {4{wd[7:0]}}; end
    else if (sz == SZ_HALF) begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wd = {2{wd[15:0]}}; end
    else                    begin e.be = 4'b1111; e.wd = wd; end
    if (!bad && ok && !w) model_rdata = ext(sz, a[1:0], s, rw);
    e.rdata = model_rdata;
    sb.push_back(e);

    we = w; size = sz; sign_ext = s; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1; nreq = 0; got = 1'b0;
    while (!got && cyc < 64) begin
      // Junk request while busy must be ignored.
      start = (cyc <= e.lat); we = ~w; size = sz + 2'd1; addr = ~a; wdata = ~wd;
      @(negedge clk);
      chk("busy_hi", busy, 1'b1);
      if (mif.mem_req) begin
        nreq++;
        chk("mem_addr", mif.mem_addr, e.maddr);
        chk("mem_be", mif.mem_be, e.be);
        chk("mem_we", mif.mem_we, e.mwe);
        if (w) chk("mem_wdata", mif.mem_wdata, e.wd);
        if (nreq == dly) begin mif.mem_ack = 1'b1; mif.mem_rdata = rw; end
      end
      if (done) begin
        got = 1'b1;
        r = sb.pop_front();
        chk("rdata", rdata, r.rdata);
        chk("addr_err", addr_err, r.aerr);
        chk("bus_err", bus_err, r.berr);
        chk("latency", cyc, r.lat);
        chk("req_cycles", nreq, r.nreq);
      end
      @(posedge clk); #1;
      mif.mem_ack = 1'b0; mif.mem_rdata = $urandom;
      cyc++;
    end
    start = 1'b0;
    if (!got) begin
      chk("done_seen", 1'b0, 1'b1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("busy_lo", busy, 1'b0);
    chk("done_lo", done, 1'b0);
    chk("req_lo", mif.mem_req, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, mif.mem_req, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_maddr"}, mif.mem_addr, 30'h0);
    chk({tag, "_be"}, mif.mem_be, 4'h0);
    chk({tag, "_wd"}, mif.mem_wdata, 32'h0);
    chk({tag, "_we"}, mif.mem_we, 1'b0);
    chk({tag, "_errs"}, {addr_err, bus_err}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store byte, ack in first REQ cycle.
    access(1'b1, SZ_BYTE, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 1);
    // Byte loads, signed and unsigned.
    access(1'b0, SZ_BYTE, 1'b1, 32'h2001, 32'h0, 32'h1234_8056, 1);
    chk("lb_signed", rdata, 32'hFFFF_FF80);
    access(1'b0, SZ_BYTE, 1'b0, 32'h2001, 32'h0, 32'h1234_8056, 1);
    chk("lb_unsigned", rdata, 32'h0000_0080);
    // Half load, upper lane, delayed ack (done in cycle 7).
    access(1'b0, SZ_HALF, 1'b1, 32'h2002, 32'h0, 32'hBEEF_0000, 6);
    chk("lh_signed", rdata, 32'hFFFF_BEEF);
    access(1'b0, SZ_HALF, 1'b0, 32'h2000, 32'h0, 32'h1234_F00D, 2);
    access(1'b0, SZ_BYTE, 1'b1, 32'h2002, 32'h0, 32'h0077_0000, 1);
    access(1'b0, SZ_WORD, 1'b1, 32'h3000, 32'h0, 32'h8765_4321, 3);
    // Stores: word and upper half.
    access(1'b1, SZ_WORD, 1'b0, 32'h0100, 32'h1234_5678, 32'h0, 3);
    access(1'b1, SZ_HALF, 1'b0, 32'h0102, 32'h5555_CAFE, 32'h0, 2);
    chk("store_keeps_rdata", rdata, 32'h8765_4321);
    // Misaligned and reserved size.
    access(1'b0, SZ_WORD, 1'b0, 32'h1002, 32'h0, 32'h0, 1);
    access(1'b1, SZ_HALF, 1'b0, 32'h1001, 32'h0, 32'h0, 1);
    access(1'b0, 2'b11,   1'b0, 32'h1000, 32'h0, 32'h0, 1);
    // Timeout, then ack exactly in the last allowed cycle.
    access(1'b0, SZ_WORD, 1'b0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0);
    chk("timeout_rdata", rdata, 32'h8765_4321);
    access(1'b0, SZ_WORD, 1'b0, 32'h4004, 32'h0, 32'hCAFE_F00D, TO);

    // Stray ack in IDLE.
    mif.mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_req", mif.mem_req, 1'b0);
      chk("stray_done", done | busy, 1'b0);
    end
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    chk("stray_rdata", rdata, 32'hCAFE_F00D);

    // Reset during REQ abandons the access with no done.
    we = 1'b0; size = SZ_WORD; addr = 32'h5000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", mif.mem_req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    model_rdata = '0;
    @(posedge clk); #1;
    access(1'b0, SZ_HALF, 1'b1, 32'h6002, 32'h0, 32'h7FFF_0001, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
